pipe_hazard_ctrl: RTL and testbench

Pipeline hazard controller for the 5-stage MIPS core. It keeps a shadow copy of the destination/control bits of instructions in EX and MEM, and generates operand-forwarding selects, load-use stalls and bubbles. It also freezes the whole pipeline while the shared data memory has not acknowledged a MEM-stage access, and raises a sticky timeout. It sits beside the ID-stage control unit, which supplies the decoded ID-stage fields.

---
 rtl/pipe_hazard_ctrl.sv | 146 ++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// Hazard controller for the 5-stage MIPS core: shadow EX/MEM tracker,
// operand forwarding, load-use stall and data-memory wait freeze.
module pipe_hazard_ctrl #(
   parameter int WAIT_MAX = 15,
   parameter int CNT_W    = 16
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             id_valid,
   input  logic [4:0]       id_rs,
   input  logic [4:0]       id_rt,
   input  logic             id_use_rs,
   input  logic             id_use_rt,
   input  logic [4:0]       id_rn,
   input  logic             id_wreg,
   input  logic             id_m2reg,
   input  logic             id_wmem,
   input  logic             dmem_ready,
   output logic [1:0]       fwda,
   output logic [1:0]       fwdb,
   output logic             stall,
   output logic             bubble,
   output logic             freeze,
   output logic             mem_timeout,
   output logic [CNT_W-1:0] stall_cnt
);

   localparam int WW = (WAIT_MAX < 1) ? 1 : $clog2(WAIT_MAX + 1);
   localparam logic [WW-1:0] WMAX = WW'(WAIT_MAX);

   typedef enum logic {RUN, MEMWAIT} state_t;

   state_t          state_q;
   logic [WW-1:0]   wait_q;
   logic            tout_q;
   logic [CNT_W-1:0] cnt_q;

   logic       ex_v_q, ex_wreg_q, ex_m2reg_q, ex_mem_q;
   logic [4:0] ex_rn_q;
   logic       mem_v_q, mem_wreg_q, mem_m2reg_q, mem_mem_q;
   logic [4:0] mem_rn_q;

   logic ex_hit_a, ex_hit_b, mem_hit_a, mem_hit_b;
   logic mem_op, load_use;

   function automatic logic hit(input logic v, input logic w,
                                input logic [4:0] rn, input logic [4:0] s,
                                input logic use_s);
      return v & w & (rn != 5'd0) & (rn == s) & use_s;
   endfunction

   function automatic logic [1:0] sel(input logic exh, input logic memh);
      if (exh && !ex_m2reg_q) return 2'b01;
      else if (memh)          return mem_m2reg_q ? 2'b11 : 2'b10;
      else                    return 2'b00;
   endfunction

   assign ex_hit_a  = hit(ex_v_q, ex_wreg_q, ex_rn_q, id_rs, id_use_rs);
   assign ex_hit_b  = hit(ex_v_q, ex_wreg_q, ex_rn_q, id_rt, id_use_rt);
   assign mem_hit_a = hit(mem_v_q, mem_wreg_q, mem_rn_q, id_rs, id_use_rs);
   assign mem_hit_b = hit(mem_v_q, mem_wreg_q, mem_rn_q, id_rt, id_use_rt);

   assign fwda = sel(ex_hit_a, mem_hit_a);
   assign fwdb = sel(ex_hit_b, mem_hit_b);

   assign mem_op   = mem_v_q & mem_mem_q;
   assign load_use = id_valid & ex_m2reg_q & (ex_hit_a | ex_hit_b);

   always_comb begin
      freeze = 1'b0;
      unique case (state_q)
         RUN:     freeze = mem_op & ~dmem_ready;
         MEMWAIT: freeze = ~dmem_ready;
      endcase
   end

   // Freeze wins: the bubble must not disturb a held ID/EX register.
   assign stall       = load_use;
   assign bubble      = load_use & ~freeze;
   assign mem_timeout = tout_q;
   assign stall_cnt   = cnt_q;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q <= RUN;
         wait_q  <= '0;
         tout_q  <= 1'b0;
      end else begin
         unique case (state_q)
            RUN: begin
               wait_q <= '0;
               if (mem_op && !dmem_ready) state_q <= MEMWAIT;
            end
            MEMWAIT: begin
               if (dmem_ready) begin
                  state_q <= RUN;
                  wait_q  <= '0;
               end else begin
                  if (wait_q != WMAX) wait_q <= wait_q + 1'b1;
                  if (wait_q == WMAX) tout_q <= 1'b1;
               end
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         ex_v_q      <= 1'b0;
         ex_rn_q     <= '0;
         ex_wreg_q   <= 1'b0;
         ex_m2reg_q  <= 1'b0;
         ex_mem_q    <= 1'b0;
         mem_v_q     <= 1'b0;
         mem_rn_q    <= '0;
         mem_wreg_q  <= 1'b0;
         mem_m2reg_q <= 1'b0;
         mem_mem_q   <= 1'b0;
      end else if (!freeze) begin
         mem_v_q     <= ex_v_q;
         mem_rn_q    <= ex_rn_q;
         mem_wreg_q  <= ex_wreg_q;
         mem_m2reg_q <= ex_m2reg_q;
         mem_mem_q   <= ex_mem_q;
         if (id_valid && !bubble) begin
            ex_v_q     <= 1'b1;
            ex_rn_q    <= id_rn;
            ex_wreg_q  <= id_wreg;
            ex_m2reg_q <= id_m2reg;
            ex_mem_q   <= id_m2reg | id_wmem;
         end else begin
            ex_v_q     <= 1'b0;
            ex_rn_q    <= '0;
            ex_wreg_q  <= 1'b0;
            ex_m2reg_q <= 1'b0;
            ex_mem_q   <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn)                       cnt_q <= '0;
      else if ((stall | freeze) && !(&cnt_q)) cnt_q <= cnt_q + 1'b1;
   end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: directed instruction sequences,
// expected outputs queued per cycle and checked by a monitor.
module tb_pipe_hazard_ctrl;

   localparam int CW = 4;

   logic clk = 1'b0;
   logic resetn = 1'b0;
   logic id_valid = 1'b0;
   logic [4:0] id_rs = '0, id_rt = '0, id_rn = '0;
   logic id_use_rs = 1'b0, id_use_rt = 1'b0;
   logic id_wreg = 1'b0, id_m2reg = 1'b0, id_wmem = 1'b0;
   logic dmem_ready = 1'b1;
   logic [1:0] fwda, fwdb;
   logic stall, bubble, freeze, mem_timeout;
   logic [CW-1:0] stall_cnt;

   pipe_hazard_ctrl #(.WAIT_MAX(15), .CNT_W(CW)) dut (
      .clk(clk), .resetn(resetn), .id_valid(id_valid),
      .id_rs(id_rs), .id_rt(id_rt),
      .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
      .id_rn(id_rn), .id_wreg(id_wreg), .id_m2reg(id_m2reg),
      .id_wmem(id_wmem), .dmem_ready(dmem_ready),
      .fwda(fwda), .fwdb(fwdb), .stall(stall), .bubble(bubble),
      .freeze(freeze), .mem_timeout(mem_timeout), .stall_cnt(stall_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      string nm;
      logic [1:0] fa, fb;
      logic st, bu, fr, to;
      int cnt;
      bit cf;
   } exp_t;

   exp_t q[$];
   int total = 0;
   int bad = 0;

   task automatic cmp(string nm, int act, int req);
      total++;
      if (act != req) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", nm, act, req);
      end
   endtask

   always @(negedge clk) begin
      if (q.size() > 0) begin
         exp_t e;
         e = q.pop_front();
         if (e.cf) begin
            cmp({e.nm, ".fwda"}, int'(fwda), int'(e.fa));
            cmp({e.nm, ".fwdb"}, int'(fwdb), int'(e.fb));
         end
         cmp({e.nm, ".stall"}, int'(stall), int'(e.st));
         cmp({e.nm, ".bubble"}, int'(bubble), int'(e.bu));
         cmp({e.nm, ".freeze"}, int'(freeze), int'(e.fr));
         cmp({e.nm, ".timeout"}, int'(mem_timeout), int'(e.to));
         cmp({e.nm, ".cnt"}, int'(stall_cnt), e.cnt);
      end
   end

   task automatic ex(string nm, logic [1:0] fa, logic [1:0] fb,
                     logic st, logic bu, logic fr, logic to,
                     int cnt, bit cf);
      exp_t e;
      e.nm = nm; e.fa = fa; e.fb = fb; e.st = st; e.bu = bu;
      e.fr = fr; e.to = to; e.cnt = cnt; e.cf = cf;
      q.push_back(e);
   endtask

   task automatic ins(logic [4:0] rs, logic [4:0] rt, logic urs,
                      logic urt, logic [4:0] rn, logic w, logic m,
                      logic wm);
      id_valid = 1'b1; id_rs = rs; id_rt = rt;
      id_use_rs = urs; id_use_rt = urt; id_rn = rn;
      id_wreg = w; id_m2reg = m; id_wmem = wm;
   endtask

   task automatic nop();
      id_valid = 1'b0; id_rs = '0; id_rt = '0;
      id_use_rs = 1'b0; id_use_rt = 1'b0; id_rn = '0;
      id_wreg = 1'b0; id_m2reg = 1'b0; id_wmem = 1'b0;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic int sat(int x);
      return (x > 15) ? 15 : x;
   endfunction

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      nop();
      repeat (2) @(posedge clk);
      #1;
      ex("reset", 2'b00, 2'b00, 0, 0, 0, 0, 0, 1);
      step();
      resetn = 1'b1;

      // ALU forwarding
      ins(5'd1, 5'd2, 1, 1, 5'd3, 1, 0, 0);
      ex("alu0", 2'b00, 2'b00, 0, 0, 0, 0, 0, 1);
      step();
      ins(5'd3, 5'd4, 1, 1, 5'd8, 1, 0, 0);
      ex("alu_ex", 2'b01, 2'b00, 0, 0, 0, 0, 0, 1);
      step();
      ins(5'd9, 5'd3, 1, 1, 5'd10, 1, 0, 0);
      ex("alu_mem", 2'b00, 2'b10, 0, 0, 0, 0, 0, 1);
      step();
      nop(); step(); step();

      // Load-use
      ins(5'd1, 5'd0, 1, 0, 5'd5, 1, 1, 0);
      ex("lw0", 2'b00, 2'b00, 0, 0, 0, 0, 0, 1);
      step();
      ins(5'd6, 5'd5, 1, 1, 5'd11, 1, 0, 0);
      ex("lu_stall", 2'b00, 2'b00, 1, 1, 0, 0, 0, 0);
      step();
      ex("lu_fwd", 2'b00, 2'b11, 0, 0, 0, 0, 1, 1);
      step();
      nop(); step(); step();

      // Register zero, including a load into r0
      ins(5'd1, 5'd2, 1, 1, 5'd0, 1, 1, 0);
      ex("r0_a", 2'b00, 2'b00, 0, 0, 0, 0, 1, 1);
      step();
      ins(5'd0, 5'd0, 1, 1, 5'd12, 1, 0, 0);
      ex("r0_ex", 2'b00, 2'b00, 0, 0, 0, 0, 1, 1);
      step();
      ins(5'd0, 5'd0, 1, 1, 5'd12, 1, 0, 0);
      ex("r0_mem", 2'b00, 2'b00, 0, 0, 0, 0, 1, 1);
      step();
      nop(); step(); step();

      // EX over MEM priority
      ins(5'd1, 5'd2, 1, 1, 5'd7, 1, 0, 0);
      step();
      ins(5'd1, 5'd2, 1, 1, 5'd7, 1, 0, 0);
      ex("pri_a", 2'b00, 2'b00, 0, 0, 0, 0, 1, 1);
      step();
      ins(5'd7, 5'd7, 1, 1, 5'd13, 1, 0, 0);
      ex("pri", 2'b01, 2'b01, 0, 0, 0, 0, 1, 1);
      step();
      nop(); step(); step();

      // Short memory wait
      ins(5'd1, 5'd0, 1, 0, 5'd5, 1, 1, 0);
      step();
      nop();
      ex("mw_ex", 2'b00, 2'b00, 0, 0, 0, 0, 1, 1);
      step();
      ins(5'd5, 5'd3, 1, 1, 5'd14, 1, 0, 0);
      for (int k = 0; k < 3; k++) begin
         dmem_ready = 1'b0;
         ex($sformatf("mw%0d", k), 2'b11, 2'b00, 0, 0, 1, 0, 1 + k, 1);
         step();
      end
      dmem_ready = 1'b1;
      ex("mw_rel", 2'b11, 2'b00, 0, 0, 0, 0, 4, 1);
      step();
      nop();
      ex("mw_after", 2'b00, 2'b00, 0, 0, 0, 0, 4, 1);
      step(); step(); step();

      // Long memory wait: timeout and stall_cnt saturation
      ins(5'd1, 5'd0, 1, 0, 5'd5, 1, 1, 0);
      step();
      nop(); step();
      for (int k = 0; k < 20; k++) begin
         dmem_ready = 1'b0;
         ex($sformatf("to%0d", k), 2'b00, 2'b00, 0, 0, 1,
            (k >= 17), sat(4 + k), 1);
         step();
      end
      dmem_ready = 1'b1;
      ex("to_rel", 2'b00, 2'b00, 0, 0, 0, 1, 15, 1);
      step();
      ex("to_sticky", 2'b00, 2'b00, 0, 0, 0, 1, 15, 1);
      step();

      // Reset in the middle of a memory wait
      ins(5'd1, 5'd0, 1, 0, 5'd5, 1, 1, 0);
      step();
      nop(); step();
      dmem_ready = 1'b0;
      ex("rw0", 2'b00, 2'b00, 0, 0, 1, 1, 15, 1);
      step();
      ex("rw1", 2'b00, 2'b00, 0, 0, 1, 1, 15, 1);
      step();
      resetn = 1'b0;
      ex("rst_mid", 2'b00, 2'b00, 0, 0, 0, 0, 0, 1);
      step();
      resetn = 1'b1;
      ex("rst_run", 2'b00, 2'b00, 0, 0, 0, 0, 0, 1);
      step();
      dmem_ready = 1'b1;

      for (int i = 0; i < 5 && q.size() > 0; i++) @(negedge clk);
      #1;
      cmp("drain", q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
